// File: rtl/conv_pixel_engine_pkg.sv
// Shared types, widths and arithmetic helpers for the conv pixel engine.
// Holds the accumulator width default, the FSM state enum, LeakyReLU and int8 requantisation.
package conv_pixel_engine_pkg;

   localparam int ACC_W       = 32;
   localparam int SCALE_Q     = 16;
   localparam int LEAKY_SHIFT = 3;
   localparam int SCALE_W     = 16;
   localparam int RQ_W        = 48;

   localparam logic signed [RQ_W-1:0] RQ_HALF = RQ_W'(1) << (SCALE_Q - 1);
   localparam logic signed [RQ_W-1:0] SAT_MAX = 127;
   localparam logic signed [RQ_W-1:0] SAT_MIN = -128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MAC,
      ST_DRAIN,
      ST_POST,
      ST_REQ,
      ST_OUT,
      ST_DONE
   } state_e;

   // Negative inputs use an arithmetic shift, so the result rounds toward minus infinity.
   function automatic logic signed [ACC_W-1:0] leaky_shift(input logic signed [ACC_W-1:0] x);
      return x[ACC_W-1] ? (x >>> LEAKY_SHIFT) : x;
   endfunction

   function automatic logic signed [7:0] requant_sat_int8(input logic signed [ACC_W-1:0] y,
                                                         input logic [SCALE_W-1:0]   scale);
      logic signed [RQ_W-1:0] y_ext;
      logic signed [RQ_W-1:0] s_ext;
      logic signed [RQ_W-1:0] t;
      logic signed [RQ_W-1:0] sh;
      y_ext = {{(RQ_W-ACC_W){y[ACC_W-1]}}, y};
      s_ext = {{(RQ_W-SCALE_W){1'b0}}, scale};
      t     = y_ext * s_ext + RQ_HALF;
      sh    = t >>> SCALE_Q;
      if (sh > SAT_MAX) begin
         return 8'sd127;
      end
      if (sh < SAT_MIN) begin
         return -8'sd128;
      end
      return 8'(sh);
   endfunction

endpackage

// File: rtl/conv_pixel_engine_if.sv
// Config, operand-fetch and result-stream bundle of the conv pixel engine.
// The master modport is the engine side; the slave modport is memories plus consumer.
interface conv_pixel_engine_if
   import conv_pixel_engine_pkg::*;
#(
   parameter int MAX_CH   = 4,
   parameter int MAX_MACS = 288
);
   localparam int NCH_W  = $clog2(MAX_CH + 1);
   localparam int NMAC_W = $clog2(MAX_MACS + 1);
   localparam int CH_W   = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
   localparam int ADDR_W = (MAX_MACS > 1) ? $clog2(MAX_MACS) : 1;

   logic                     start;
   logic [NCH_W-1:0]         num_ch;
   logic [NMAC_W-1:0]        num_macs;
   logic [SCALE_W-1:0]       scale;
   logic [ADDR_W-1:0]        act_addr;
   logic signed [7:0]        act_rdata;
   logic [CH_W-1:0]          w_ch;
   logic [ADDR_W-1:0]        w_addr;
   logic signed [7:0]        w_rdata;
   logic signed [ACC_W-1:0]  bias_rdata;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [7:0]        out_data;
   logic [CH_W-1:0]          out_ch;
   logic                     busy;
   logic                     done;
   logic                     cfg_err;

   modport master (
      input  start, num_ch, num_macs, scale, act_rdata, w_rdata, bias_rdata, out_ready,
      output act_addr, w_ch, w_addr, out_valid, out_data, out_ch, busy, done, cfg_err
   );

   modport slave (
      output start, num_ch, num_macs, scale, act_rdata, w_rdata, bias_rdata, out_ready,
      input  act_addr, w_ch, w_addr, out_valid, out_data, out_ch, busy, done, cfg_err
   );

endinterface

// File: rtl/conv_pixel_engine_post.sv
// Post-accumulation pipeline: bias + LeakyReLU register, then requantise-to-int8 register.
module pixel_post
   import conv_pixel_engine_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    post_en,
   input  logic                    req_en,
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [ACC_W-1:0] bias,
   input  logic [SCALE_W-1:0]      scale,
   output logic signed [7:0]       res
);

   logic signed [ACC_W-1:0] y_q, y_d;
   logic signed [7:0]       r_q, r_d;

   always_comb begin
      y_d = y_q;
      r_d = r_q;
      if (post_en) begin
         y_d = leaky_shift(acc + bias);
      end
      if (req_en) begin
         r_d = requant_sat_int8(y_q, scale);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= '0;
         r_q <= '0;
      end else begin
         y_q <= y_d;
         r_q <= r_d;
      end
   end

   assign res = r_q;

endmodule

// File: rtl/conv_pixel_engine.sv
// One output pixel over num_ch channels: one int8 MAC per cycle, then bias, LeakyReLU and
// int8 requantisation, with each channel's result handed out on a valid/ready stream.
module conv_pixel_engine
   import conv_pixel_engine_pkg::*;
#(
   parameter int MAX_CH   = 4,
   parameter int MAX_MACS = 288
)
(
   input  logic                  clk,
   input  logic                  rst,
   conv_pixel_engine_if.master   bus
);

   localparam int NCH_W  = $clog2(MAX_CH + 1);
   localparam int NMAC_W = $clog2(MAX_MACS + 1);
   localparam int CH_W   = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
   localparam int ADDR_W = (MAX_MACS > 1) ? $clog2(MAX_MACS) : 1;

   state_e                  state_q, state_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [ADDR_W-1:0]       mac_cnt_q, mac_cnt_d;
   logic [NCH_W-1:0]        num_ch_q, num_ch_d;
   logic [NMAC_W-1:0]       num_macs_q, num_macs_d;
   logic [SCALE_W-1:0]      scale_q, scale_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    acc_en_q, acc_en_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [7:0]       out_data_q, out_data_d;
   logic [CH_W-1:0]         out_ch_q, out_ch_d;
   logic                    cfg_err_q, cfg_err_d;

   logic signed [7:0]       post_res;
   logic signed [15:0]      prod;
   logic                    cfg_ok;
   logic                    last_mac;
   logic                    last_ch;
   logic                    handshake;

   always_comb begin
      cfg_ok    = (bus.num_ch != '0) && (bus.num_ch <= NCH_W'(MAX_CH)) &&
                  (bus.num_macs != '0) && (bus.num_macs <= NMAC_W'(MAX_MACS));
      last_mac  = (NMAC_W'(mac_cnt_q) == (num_macs_q - NMAC_W'(1)));
      last_ch   = (NCH_W'(ch_q) == (num_ch_q - NCH_W'(1)));
      handshake = out_valid_q && bus.out_ready;
      prod      = bus.w_rdata * bus.act_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start && cfg_ok) state_d = ST_MAC;
         ST_MAC:   if (last_mac) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_POST;
         ST_POST:  state_d = ST_REQ;
         ST_REQ:   state_d = ST_OUT;
         ST_OUT:   if (handshake) state_d = last_ch ? ST_DONE : ST_MAC;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Read data trails its address by one cycle, so acc_en_q marks the cycles carrying a product.
   always_comb begin
      ch_d        = ch_q;
      mac_cnt_d   = mac_cnt_q;
      num_ch_d    = num_ch_q;
      num_macs_d  = num_macs_q;
      scale_d     = scale_q;
      acc_d       = acc_q;
      acc_en_d    = (state_q == ST_MAC);
      out_valid_d = (state_q == ST_OUT) && !handshake;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      cfg_err_d   = 1'b0;

      if (state_q == ST_IDLE && bus.start) begin
         if (cfg_ok) begin
            num_ch_d   = bus.num_ch;
            num_macs_d = bus.num_macs;
            scale_d    = bus.scale;
            ch_d       = '0;
         end else begin
            cfg_err_d  = 1'b1;
         end
      end

      if (acc_en_q) begin
         acc_d = acc_q + ACC_W'(prod);
      end

      if (state_d == ST_MAC && state_q != ST_MAC) begin
         mac_cnt_d = '0;
         acc_d     = '0;
      end else if (state_q == ST_MAC && !last_mac) begin
         mac_cnt_d = mac_cnt_q + ADDR_W'(1);
      end

      if (state_q == ST_OUT && !out_valid_q) begin
         out_data_d = post_res;
         out_ch_d   = ch_q;
      end

      if (state_q == ST_OUT && handshake && !last_ch) begin
         ch_d = ch_q + CH_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q        <= '0;
         mac_cnt_q   <= '0;
         num_ch_q    <= '0;
         num_macs_q  <= '0;
         scale_q     <= '0;
         acc_q       <= '0;
         acc_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         ch_q        <= ch_d;
         mac_cnt_q   <= mac_cnt_d;
         num_ch_q    <= num_ch_d;
         num_macs_q  <= num_macs_d;
         scale_q     <= scale_d;
         acc_q       <= acc_d;
         acc_en_q    <= acc_en_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   pixel_post u_post (
      .clk     (clk),
      .rst     (rst),
      .post_en (state_q == ST_POST),
      .req_en  (state_q == ST_REQ),
      .acc     (acc_q),
      .bias    (bus.bias_rdata),
      .scale   (scale_q),
      .res     (post_res)
   );

   always_comb begin
      bus.act_addr  = mac_cnt_q;
      bus.w_addr    = mac_cnt_q;
      bus.w_ch      = ch_q;
      bus.out_valid = out_valid_q;
      bus.out_data  = out_data_q;
      bus.out_ch    = out_ch_q;
      bus.busy      = (state_q != ST_IDLE);
      bus.done      = (state_q == ST_DONE);
      bus.cfg_err   = cfg_err_q;
   end

endmodule

// File: tb/tb_conv_pixel_engine.sv
// Directed self-checking bench for conv_pixel_engine with synchronous-read operand memories.
module tb_conv_pixel_engine;

   logic clk;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   done_cnt     = 0;

   logic signed [7:0]  act_mem [288];
   logic signed [7:0]  w_mem   [4][288];
   logic signed [31:0] bias_mem [4];

   conv_pixel_engine_if #(.MAX_CH(4), .MAX_MACS(288)) bus ();

   conv_pixel_engine #(.MAX_CH(4), .MAX_MACS(288)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.act_rdata <= act_mem[int'(bus.act_addr)];
      bus.w_rdata   <= w_mem[int'(bus.w_ch)][int'(bus.w_addr)];
   end

   assign bus.bias_rdata = bias_mem[int'(bus.w_ch)];

   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic start_pixel(input int nch, input int nmac, input int sc);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.num_ch   = 3'(nch);
      bus.num_macs = 9'(nmac);
      bus.scale    = 16'(sc);
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   // Returns the number of falling edges waited until out_valid; equals budget on timeout.
   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      tests_run++;
      if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      tests_run++;
      if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
      tests_run++;
      if (bus.cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", bus.cfg_err); end
      tests_run++;
      if (bus.out_data !== 8'sd0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %0d expected 0", bus.out_data); end
      tests_run++;
      if (bus.act_addr !== 9'd0) begin tests_failed++; $display("[TB] FAIL reset_act_addr: got %0d expected 0", bus.act_addr); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int lat;
      act_mem[0] = 8'sd3; w_mem[0][0] = 8'sd2; bias_mem[0] = 0;
      start_pixel(1, 1, 32768);
      wait_valid(20, lat);
      tests_run++;
      if (lat !== 5) begin tests_failed++; $display("[TB] FAIL single_latency: got %0d expected 5", lat); end
      tests_run++;
      if (bus.out_data !== 8'sd3) begin tests_failed++; $display("[TB] FAIL single_data: got %0d expected 3", bus.out_data); end
      tests_run++;
      if (bus.out_ch !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_ch: got %0d expected 0", bus.out_ch); end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_done: got done=%b busy=%b expected done=1 busy=1", bus.done, bus.busy); end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_idle: got done=%b busy=%b expected done=0 busy=0", bus.done, bus.busy); end
   endtask

   task automatic test_leaky();
      int lat;
      act_mem[0] = 8'sd100; w_mem[0][0] = -8'sd1; bias_mem[0] = 0;
      start_pixel(1, 1, 32768);
      wait_valid(20, lat);
      tests_run++;
      if (bus.out_data !== -8'sd6) begin tests_failed++; $display("[TB] FAIL leaky_data: got %0d expected -6", bus.out_data); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturate();
      int lat;
      for (int k = 0; k < 288; k++) begin act_mem[k] = 8'sd127; w_mem[0][k] = 8'sd127; end
      bias_mem[0] = 0;
      start_pixel(1, 288, 655);
      wait_valid(400, lat);
      tests_run++;
      if (lat !== 292) begin tests_failed++; $display("[TB] FAIL sat_pos_latency: got %0d expected 292", lat); end
      tests_run++;
      if (bus.out_data !== 8'sd127) begin tests_failed++; $display("[TB] FAIL sat_pos_data: got %0d expected 127", bus.out_data); end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 288; k++) w_mem[0][k] = -8'sd128;
      start_pixel(1, 288, 65535);
      wait_valid(400, lat);
      tests_run++;
      if (bus.out_data !== -8'sd128) begin tests_failed++; $display("[TB] FAIL sat_neg_data: got %0d expected -128", bus.out_data); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int lat;
      int d0;
      logic signed [7:0] exp_d [4];
      logic [19:0] want;
      logic [19:0] got;
      exp_d = '{8'sd1, 8'sd2, 8'sd4, 8'sd5};
      act_mem[0] = 8'sd3; act_mem[1] = -8'sd2;
      for (int c = 0; c < 4; c++) begin
         w_mem[c][0] = 8'(c + 1); w_mem[c][1] = 8'sd1; bias_mem[c] = 0;
      end
      d0 = done_cnt;
      start_pixel(4, 2, 32768);
      for (int c = 0; c < 4; c++) begin
         wait_valid(20, lat);
         tests_run++;
         if (lat !== 6) begin tests_failed++; $display("[TB] FAIL b2b_latency ch%0d: got %0d expected 6", c, lat); end
         tests_run++;
         if (bus.out_ch !== 2'(c)) begin tests_failed++; $display("[TB] FAIL b2b_ch: got %0d expected %0d", bus.out_ch, c); end
         tests_run++;
         if (bus.out_data !== exp_d[c]) begin tests_failed++; $display("[TB] FAIL b2b_data ch%0d: got %0d expected %0d", c, bus.out_data, exp_d[c]); end
         if (c == 1) begin
            bus.out_ready = 1'b0;
            want = {1'b1, 2'd1, exp_d[1], 9'd1};
            for (int s = 0; s < 10; s++) begin
               @(negedge clk);
               got = {bus.out_valid, bus.out_ch, bus.out_data, bus.act_addr};
               tests_run++;
               if (got !== want) begin tests_failed++; $display("[TB] FAIL stall_hold cycle%0d: got %h expected %h", s, got, want); end
            end
            bus.out_ready = 1'b1;
         end
         @(negedge clk);
      end
      tests_run++;
      if (bus.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_done: got %b expected 1", bus.done); end
      repeat (6) @(negedge clk);
      tests_run++;
      if (done_cnt - d0 !== 1) begin tests_failed++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_cfg_err();
      int nch [4];
      int nmac [4];
      nch  = '{1, 0, 5, 1};
      nmac = '{0, 1, 1, 289};
      for (int i = 0; i < 4; i++) begin
         start_pixel(nch[i], nmac[i], 32768);
         tests_run++;
         if (bus.cfg_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cfg_err_pulse case%0d: got %b expected 1", i, bus.cfg_err); end
         tests_run++;
         if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_err_busy case%0d: got %b expected 0", i, bus.busy); end
         @(negedge clk);
         tests_run++;
         if (bus.cfg_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL cfg_err_width case%0d: got %b expected 0", i, bus.cfg_err); end
      end
   endtask

   task automatic test_start_while_busy();
      int lat;
      int n;
      int d0;
      for (int k = 0; k < 3; k++) begin act_mem[k] = 8'(k + 1); w_mem[0][k] = 8'sd4; end
      bias_mem[0] = 0;
      d0 = done_cnt;
      start_pixel(1, 3, 32768);
      repeat (2) @(negedge clk);
      start_pixel(4, 1, 32768);
      wait_valid(30, lat);
      tests_run++;
      if (bus.out_data !== 8'sd12) begin tests_failed++; $display("[TB] FAIL busy_start_data: got %0d expected 12", bus.out_data); end
      tests_run++;
      if (bus.out_ch !== 2'd0) begin tests_failed++; $display("[TB] FAIL busy_start_ch: got %0d expected 0", bus.out_ch); end
      @(negedge clk);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) n++;
      end
      tests_run++;
      if (n !== 0) begin tests_failed++; $display("[TB] FAIL busy_start_extra_valid: got %0d expected 0", n); end
      tests_run++;
      if (done_cnt - d0 !== 1) begin tests_failed++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      int lat;
      int n;
      int d0;
      start_pixel(1, 288, 655);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_outputs: got busy=%b valid=%b expected 0 0", bus.busy, bus.out_valid); end
      tests_run++;
      if (bus.act_addr !== 9'd0) begin tests_failed++; $display("[TB] FAIL midrst_addr: got %0d expected 0", bus.act_addr); end
      rst = 1'b0;
      d0 = done_cnt;
      n = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) n++;
      end
      tests_run++;
      if (n !== 0 || done_cnt !== d0) begin tests_failed++; $display("[TB] FAIL midrst_quiet: got valid=%0d done=%0d expected 0 0", n, done_cnt - d0); end
      act_mem[0] = 8'sd3; w_mem[0][0] = 8'sd2; bias_mem[0] = 0;
      start_pixel(1, 1, 32768);
      wait_valid(20, lat);
      tests_run++;
      if (lat !== 5 || bus.out_data !== 8'sd3) begin tests_failed++; $display("[TB] FAIL midrst_rerun: got lat=%0d data=%0d expected 5 3", lat, bus.out_data); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_golden();
      int lat;
      logic signed [7:0] exp_d [4];
      exp_d = '{8'sd4, -8'sd7, -8'sd25, 8'sd127};
      for (int k = 0; k < 288; k++) begin
         act_mem[k]  = (k < 144) ? 8'sd1 : 8'sd2;
         w_mem[0][k] = 8'sd1;
         w_mem[1][k] = -8'sd1;
         w_mem[2][k] = (k % 2 == 0) ? 8'sd2 : -8'sd1;
         w_mem[3][k] = 8'sd0;
      end
      bias_mem = '{32'sd10, -32'sd5000, -32'sd20000, 32'sd100000};
      start_pixel(4, 288, 655);
      for (int c = 0; c < 4; c++) begin
         wait_valid(400, lat);
         tests_run++;
         if (lat !== 292) begin tests_failed++; $display("[TB] FAIL golden_latency ch%0d: got %0d expected 292", c, lat); end
         tests_run++;
         if (bus.out_data !== exp_d[c] || bus.out_ch !== 2'(c)) begin tests_failed++; $display("[TB] FAIL golden_data ch%0d: got %0d on ch%0d expected %0d", c, bus.out_data, bus.out_ch, exp_d[c]); end
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.num_ch    = '0;
      bus.num_macs  = '0;
      bus.scale     = '0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 288; k++) begin
         act_mem[k] = '0;
         for (int c = 0; c < 4; c++) w_mem[c][k] = '0;
      end
      for (int c = 0; c < 4; c++) bias_mem[c] = '0;

      test_reset();
      test_single();
      test_leaky();
      test_saturate();
      test_back_to_back();
      test_cfg_err();
      test_start_while_busy();
      test_reset_mid();
      test_golden();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
